// File: rtl/branch_fetch_redirect.sv
// branch_fetch_redirect: fetch PC sequencer with a 2-entry instruction queue.
// It keeps at most one instruction-memory request in flight, redirects on
// taken branches, and discards the fetch that was in flight when a redirect
// arrived.
// Optional build macro BRANCH_FETCH_PERF_EN adds the redirect_cnt and
// squash_cnt saturating performance counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no request outstanding (queue full, or just out of reset)
// ST_REQ   | imem_req high for fetch_pc, waiting for imem_ack
// ST_DRAIN | wrong-path request still outstanding, its data will be dropped
module branch_fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               id_ready,
    output logic               flush,
    output logic               misalign_err
`ifdef BRANCH_FETCH_PERF_EN
    ,
    output logic [31:0]        redirect_cnt,
    output logic [31:0]        squash_cnt
`endif
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_REQ   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [31:0] STEP     = 32'(PC_STEP);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_pc_nxt;
    logic [31:0]        req_addr;
    logic [31:0]        req_addr_nxt;

    logic [31:0]        q_pc        [2];
    logic [INSTR_W-1:0] q_instr     [2];
    logic [31:0]        q_pc_nxt    [2];
    logic [INSTR_W-1:0] q_instr_nxt [2];
    logic [1:0]         q_cnt;
    logic [1:0]         q_cnt_nxt;

    logic               redirect;
    logic [31:0]        target_aligned;
    logic               ack_live;
    logic               push;
    logic               pop;
    logic               push_slot;

    assign redirect       = br_valid && br_taken;
    assign target_aligned = {br_target[31:2], 2'b00};
    assign ack_live       = imem_ack && (state != ST_IDLE);
    assign pop            = (q_cnt != 2'd0) && id_ready;
    // Only a correct-path ack with no redirect this cycle delivers an entry.
    assign push           = ack_live && (state == ST_REQ) && !redirect;
    assign push_slot      = !((q_cnt == 2'd0) || ((q_cnt == 2'd1) && pop));

    assign imem_req  = (state != ST_IDLE);
    assign imem_addr = req_addr;
    assign if_valid  = (q_cnt != 2'd0);
    assign if_pc     = q_pc[0];
    assign if_instr  = q_instr[0];

    // Queue next-state: shift on pop, write behind the surviving entries on push.
    always_comb begin
        q_pc_nxt    = q_pc;
        q_instr_nxt = q_instr;
        q_cnt_nxt   = q_cnt;
        if (redirect) begin
            q_cnt_nxt = 2'd0;
        end else begin
            if (pop) begin
                q_pc_nxt[0]    = q_pc[1];
                q_instr_nxt[0] = q_instr[1];
            end
            if (push) begin
                q_pc_nxt[push_slot]    = req_addr;
                q_instr_nxt[push_slot] = imem_data;
            end
            q_cnt_nxt = q_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Fetch FSM and PC update; the request address is frozen only while draining.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        case (state)
            ST_IDLE: begin
                if (q_cnt_nxt != 2'd2) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    state_nxt = imem_ack ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    fetch_pc_nxt = fetch_pc + STEP;
                    state_nxt    = (q_cnt_nxt != 2'd2) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (redirect) fetch_pc_nxt = target_aligned;
        req_addr_nxt = (state_nxt == ST_DRAIN) ? req_addr : fetch_pc_nxt;
    end

    // Register FSM, PCs, queue and the one-cycle redirect pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            fetch_pc     <= RESET_PC;
            req_addr     <= RESET_PC;
            q_cnt        <= 2'd0;
            q_pc[0]      <= '0;
            q_pc[1]      <= '0;
            q_instr[0]   <= '0;
            q_instr[1]   <= '0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            req_addr     <= req_addr_nxt;
            q_cnt        <= q_cnt_nxt;
            q_pc[0]      <= q_pc_nxt[0];
            q_pc[1]      <= q_pc_nxt[1];
            q_instr[0]   <= q_instr_nxt[0];
            q_instr[1]   <= q_instr_nxt[1];
            flush        <= redirect;
            misalign_err <= redirect && (br_target[1:0] != 2'b00);
        end
    end

`ifdef BRANCH_FETCH_PERF_EN
    logic        dropped;
    logic [2:0]  squash_inc;
    logic [32:0] redirect_sum;
    logic [32:0] squash_sum;

    // A dropped fetch is one whose ack lands while draining or alongside a redirect.
    assign dropped      = ack_live && ((state == ST_DRAIN) || redirect);
    assign squash_inc   = (redirect ? {1'b0, q_cnt} : 3'd0) + {2'b00, dropped};
    assign redirect_sum = {1'b0, redirect_cnt} + {32'd0, redirect};
    assign squash_sum   = {1'b0, squash_cnt} + {30'd0, squash_inc};

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt <= 32'd0;
            squash_cnt   <= 32'd0;
        end else begin
            redirect_cnt <= redirect_sum[32] ? 32'hFFFF_FFFF : redirect_sum[31:0];
            squash_cnt   <= squash_sum[32] ? 32'hFFFF_FFFF : squash_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_branch_fetch_redirect.sv
// Self-checking bench for branch_fetch_redirect: directed scenarios followed
// by randomized branches, acks and decode back-pressure, all compared against
// a queue-based reference model of the fetch stream.
module tb_branch_fetch_redirect;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        imem_ack = 1'b0;
    logic        id_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        misalign_err;
`ifdef BRANCH_FETCH_PERF_EN
    logic [31:0] redirect_cnt;
    logic [31:0] squash_cnt;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_data = mem_word(imem_addr);

    branch_fetch_redirect #(
        .RESET_PC (RST_PC),
        .PC_STEP  (4),
        .INSTR_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .id_ready     (id_ready),
        .flush        (flush),
        .misalign_err (misalign_err)
`ifdef BRANCH_FETCH_PERF_EN
        ,
        .redirect_cnt (redirect_cnt),
        .squash_cnt   (squash_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model: fetch PC, the single in-flight request, and the queue.
    entry_t      m_q[$];
    logic [31:0] m_pc    = RST_PC;
    logic        m_out   = 1'b0;
    logic        m_wrong = 1'b0;
    logic [31:0] m_addr  = RST_PC;
    logic        m_flush = 1'b0;
    logic        m_mis   = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int flush_seen = 0;
    int mis_seen = 0;
    logic [31:0] acc_pc[$];
    int          acc_cyc[$];
    logic [31:0] seen_instr[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic   redir;
        logic   acked;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_pc    = RST_PC;
            m_out   = 1'b0;
            m_wrong = 1'b0;
            m_addr  = RST_PC;
            m_flush = 1'b0;
            m_mis   = 1'b0;
        end else begin
            redir = br_valid && br_taken;
            acked = imem_ack && m_out;
            if (m_q.size() != 0 && id_ready) void'(m_q.pop_front());
            if (acked && !m_wrong && !redir) begin
                e.pc    = m_addr;
                e.instr = mem_word(m_addr);
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (acked) m_out = 1'b0;
            if (redir) begin
                m_q.delete();
                m_pc = {br_target[31:2], 2'b00};
                if (m_out) m_wrong = 1'b1;
            end
            m_flush = redir;
            m_mis   = redir && (br_target[1:0] != 2'b00);
            if (!m_out && m_q.size() < 2) begin
                m_out   = 1'b1;
                m_addr  = m_pc;
                m_wrong = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("imem_req", 32'(imem_req), 32'(m_out));
        if (m_out) check_val("imem_addr", imem_addr, m_addr);
        check_val("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("if_pc", if_pc, m_q[0].pc);
            check_val("if_instr", if_instr, m_q[0].instr);
        end
        check_val("flush", 32'(flush), 32'(m_flush));
        check_val("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    // One clock: drive inputs, step model at the edge, compare 1 time unit later.
    task automatic cycle(input logic r, input logic bv, input logic bt,
                         input logic [31:0] tgt, input logic ack_en, input logic rdy);
        rst       = r;
        br_valid  = bv;
        br_taken  = bt;
        br_target = tgt;
        imem_ack  = ack_en && m_out;
        id_ready  = rdy;
        if (!r && if_valid === 1'b1 && id_ready) begin
            acc_pc.push_back(if_pc);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare_all();
        if (flush === 1'b1) flush_seen++;
        if (misalign_err === 1'b1) mis_seen++;
        if (if_valid === 1'b1) seen_instr.push_back(if_instr);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    endtask

    initial begin
        logic        r, bv, bt, ak, rd;
        logic [31:0] tg;
        int          hits;

        // Reset values
        do_reset();
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_imem_addr", imem_addr, 32'h0000_0100);
        check_val("rst_if_valid", 32'(if_valid), 32'd0);
        check_val("rst_if_pc", if_pc, 32'd0);
        check_val("rst_if_instr", if_instr, 32'd0);
        check_val("rst_flush", 32'(flush), 32'd0);
        check_val("rst_misalign", 32'(misalign_err), 32'd0);

        // Full throughput from reset
        acc_pc.delete(); acc_cyc.delete(); flush_seen = 0;
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_val("tput_pc0", acc_pc[0], 32'h100);
        check_val("tput_pc1", acc_pc[1], 32'h104);
        check_val("tput_pc2", acc_pc[2], 32'h108);
        check_val("tput_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        check_val("tput_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
        check_val("tput_flush", 32'(flush_seen), 32'd0);

        // Decode stalled: queue fills with two entries, requests stop
        do_reset();
        repeat (7) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_val("stall_if_valid", 32'(if_valid), 32'd1);
        check_val("stall_if_pc", if_pc, 32'h100);
        check_val("stall_req", 32'(imem_req), 32'd0);
        acc_pc.delete(); acc_cyc.delete();
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_val("stall_pc0", acc_pc[0], 32'h100);
        check_val("stall_pc1", acc_pc[1], 32'h104);
        check_val("stall_pc2", acc_pc[2], 32'h108);
        check_val("stall_pc3", acc_pc[3], 32'h10C);

        // Redirect while 0x108 is in flight; ack arrives three cycles later
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_val("pre_redir_addr", imem_addr, 32'h108);
        flush_seen = 0;
        cycle(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b1);
        seen_instr.delete(); acc_pc.delete(); acc_cyc.delete();
        check_val("drain_req", 32'(imem_req), 32'd1);
        check_val("drain_addr", imem_addr, 32'h108);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_val("post_drain_req", 32'(imem_req), 32'd1);
        check_val("post_drain_addr", imem_addr, 32'h400);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        hits = 0;
        foreach (seen_instr[i]) if (seen_instr[i] == mem_word(32'h108)) hits++;
        check_val("wrong_path_seen", 32'(hits), 32'd0);
        check_val("redir_flush_cnt", 32'(flush_seen), 32'd1);
        check_val("redir_first_pc", acc_pc[0], 32'h400);

        // Misaligned target
        mis_seen = 0;
        cycle(1'b0, 1'b1, 1'b1, 32'h203, 1'b1, 1'b1);
        check_val("mis_pulse", 32'(misalign_err), 32'd1);
        check_val("mis_addr", imem_addr, 32'h200);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_val("mis_cnt", 32'(mis_seen), 32'd1);

        // PC wrap
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        check_val("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_val("wrap_addr1", imem_addr, 32'h0000_0000);
        check_val("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Not-taken branches every cycle leave the stream alone
        do_reset();
        flush_seen = 0; acc_pc.delete(); acc_cyc.delete();
        repeat (20) cycle(1'b0, 1'b1, 1'b0, $urandom, 1'b1, 1'b1);
        check_val("nt_flush", 32'(flush_seen), 32'd0);
        check_val("nt_first", acc_pc[0], 32'h100);
        check_val("nt_count_ok", 32'(acc_pc.size() >= 15), 32'd1);
        for (int i = 1; i < acc_pc.size(); i++)
            check_val("nt_seq", acc_pc[i], acc_pc[i-1] + 32'd4);
`ifdef BRANCH_FETCH_PERF_EN
        check_val("nt_redirect_cnt", redirect_cnt, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            bv = ($urandom_range(0, 5) == 0);
            bt = 1'($urandom_range(0, 1));
            tg = $urandom;
            if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'h0000_000F);
            ak = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 70);
            cycle(r, bv, bt, tg, ak, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
